// File: rtl/ctrl_encode_def.sv
// rtl/ctrl_encode_def.sv - shared DMType encodings and load/store FSM state encodings
package ctrl_encode_def;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane/byte-enable generation, misalign check, load lane extraction and extension
module lsu_align
    import ctrl_encode_def::*;
(
    input  logic [1:0]  i_st_addr_lo,
    input  logic [2:0]  i_st_type,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    output logic        o_misalign,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [2:0]  i_ld_type,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        o_misalign = 1'b0;
        case (i_st_type)
            dm_halfword, dm_halfword_unsigned: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_wdata[15:0]}};
                o_misalign = i_st_addr_lo[0];
            end
            dm_byte, dm_byte_unsigned: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            // Word, and every unused encoding, behaves as a word access
            default: o_misalign = (i_st_addr_lo != 2'b00);
        endcase
    end

    always_comb begin
        w_byte = i_ld_word[7:0];
        case (i_ld_addr_lo)
            2'b01:   w_byte = i_ld_word[15:8];
            2'b10:   w_byte = i_ld_word[23:16];
            2'b11:   w_byte = i_ld_word[31:24];
            default: w_byte = i_ld_word[7:0];
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_type)
            dm_halfword:          o_ld_data = {{16{w_half[15]}}, w_half};
            dm_halfword_unsigned: o_ld_data = {16'h0000, w_half};
            dm_byte:              o_ld_data = {{24{w_byte[7]}}, w_byte};
            dm_byte_unsigned:     o_ld_data = {24'h000000, w_byte};
            default:              o_ld_data = i_ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: one bus transaction per op, stall, timeout and misalign pulses
module mem_access_unit
    import ctrl_encode_def::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        op_valid,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state, w_next;
    logic [31:0]       r_addr, r_wdata, r_rdata;
    logic [3:0]        r_be;
    logic [2:0]        r_type;
    logic              r_we, r_mis;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_start, w_mis;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_wdata, w_ld_data;

    assign w_start = op_valid & (mem_we | mem_re);

    lsu_align u_align (
        .i_st_addr_lo (addr[1:0]),
        .i_st_type    (dm_type),
        .i_st_wdata   (wdata),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .o_misalign   (w_mis),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_ld_type    (r_type),
        .i_ld_word    (bus_rdata),
        .o_ld_data    (w_ld_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = w_mis ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (bus_ack)                    w_next = ST_DONE;
                else if (r_cnt == LP_CNT_LAST)  w_next = ST_ERR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= '0;
            r_type  <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_start) begin
                r_addr  <= addr;
                r_type  <= dm_type;
                r_we    <= mem_we;
                r_be    <= mem_we ? w_st_be : 4'b1111;
                r_wdata <= mem_we ? w_st_wdata : 32'h0;
                r_mis   <= w_mis;
                r_cnt   <= '0;
            end
            if (r_state == ST_REQ) begin
                r_cnt <= r_cnt + 1'b1;
                if (bus_ack && !r_we) r_rdata <= w_ld_data;
            end
        end
    end

    // ERR is shared by both abort causes; r_mis tells them apart
    assign stall     = ((r_state == ST_IDLE) & w_start) | (r_state == ST_REQ);
    assign done      = (r_state == ST_DONE);
    assign misalign  = (r_state == ST_ERR) & r_mis;
    assign bus_err   = (r_state == ST_ERR) & ~r_mis;
    assign bus_req   = (r_state == ST_REQ);
    assign bus_we    = (r_state == ST_REQ) & r_we;
    assign bus_be    = (r_state == ST_REQ) ? r_be : 4'b0000;
    assign bus_addr  = {r_addr[31:2], 2'b00};
    assign bus_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule
